// File: rtl/regfile_param.sv
// regfile_param: parametrised 2-read/1-write register file with a per-register pending-write scoreboard.
// Reads are registered (1 cycle); re=0 holds out1/out2/busy1/busy2 for stalls, with no other backpressure.
module regfile_param #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd,
  input  logic              we,
  input  logic [XLEN-1:0]   inf,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_rd,
  output logic [XLEN-1:0]   out1,
  output logic [XLEN-1:0]   out2,
  output logic              busy1,
  output logic              busy2
);

  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [XLEN-1:0]  rf [NREGS];
  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_nxt;

  // A register number is "real" when it is implemented and not the hardwired zero.
  function automatic logic valid_reg(input logic [ADDR_W-1:0] r);
    return (int'(r) < NREGS) && !((ZERO_REG != 0) && (r == '0));
  endfunction

  logic          wr_ok, set_ok, rs1_ok, rs2_ok;
  logic [IW-1:0] rd_i, sb_i, rs1_i, rs2_i;

  assign wr_ok  = we && valid_reg(rd);
  assign set_ok = sb_set && valid_reg(sb_rd);
  assign rs1_ok = valid_reg(rs1);
  assign rs2_ok = valid_reg(rs2);
  assign rd_i   = rd[IW-1:0];
  assign sb_i   = sb_rd[IW-1:0];
  assign rs1_i  = rs1[IW-1:0];
  assign rs2_i  = rs2[IW-1:0];

  // Set is applied after clear so a re-issued producer stays outstanding.
  always_comb begin
    pend_nxt = pend;
    if (wr_ok)  pend_nxt[rd_i] = 1'b0;
    if (set_ok) pend_nxt[sb_i] = 1'b1;
  end

  logic [XLEN-1:0] rdata1, rdata2;
  logic            rbusy1, rbusy2;

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (rs1_ok) rdata1 = ((BYPASS != 0) && wr_ok && (rd == rs1)) ? inf : rf[rs1_i];
    if (rs2_ok) rdata2 = ((BYPASS != 0) && wr_ok && (rd == rs2)) ? inf : rf[rs2_i];
    rbusy1 = rs1_ok && pend_nxt[rs1_i];
    rbusy2 = rs2_ok && pend_nxt[rs2_i];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      pend  <= '0;
      out1  <= '0;
      out2  <= '0;
      busy1 <= 1'b0;
      busy2 <= 1'b0;
    end else begin
      if (wr_ok) rf[rd_i] <= inf;
      pend <= pend_nxt;
      if (re) begin
        out1  <= rdata1;
        out2  <= rdata2;
        busy1 <= rbusy1;
        busy2 <= rbusy2;
      end
    end
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the single-cycle 32x32 register file.
- Two registered read ports and one write port, with configurable width and depth.
- Optional hardwired-zero register 0 and optional write-to-read bypass.
- Read-enable hold for pipeline stalls, plus a per-register pending-write scoreboard so the decode stage can detect RAW hazards.
- Sits between decode (reads, scoreboard set) and writeback (write, scoreboard clear).

Parameters:
- XLEN, 32, data width of each register and of inf/out1/out2.
- NREGS, 32, number of registers implemented; range 2..2^ADDR_W.
- ADDR_W, 5, width of rs1/rs2/rd/sb_rd.
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and is never busy.
- BYPASS, 1, 1 = same-cycle write data is forwarded to a read of the same register.

Ports:
- clock  input  1  single clock, all state updates on posedge.
- reset  input  1  synchronous, active-high; sampled on posedge clock.
- rs1  input  ADDR_W  read port 1 register number.
- rs2  input  ADDR_W  read port 2 register number.
- re  input  1  read enable; 0 = out1/out2/busy1/busy2 hold.
- rd  input  ADDR_W  write register number.
- we  input  1  write enable.
- inf  input  XLEN  write data.
- sb_set  input  1  mark register sb_rd as pending (instruction issued).
- sb_rd  input  ADDR_W  register to mark pending.
- out1  output  XLEN  registered read data, port 1.
- out2  output  XLEN  registered read data, port 2.
- busy1  output  1  registered pending flag of rs1.
- busy2  output  1  registered pending flag of rs2.

Behaviour:
- Reset (reset=1 at posedge):
  - All NREGS registers cleared to 0.
  - All pending bits cleared.
  - out1, out2, busy1, busy2 = 0.
  - Reset overrides we, sb_set and re in that cycle.
- Write: at posedge with we=1 and reset=0, rf[rd] <= inf. The write is ignored when:
  - rd >= NREGS, or
  - rd == 0 and ZERO_REG=1.
- Read latency is 1 cycle. At posedge with re=1:
  - out1 <= value(rs1); out2 <= value(rs2).
  - value(r) = 0 if r >= NREGS, or if r == 0 and ZERO_REG=1.
  - Otherwise value(r) = inf if BYPASS=1 and the write above is accepted with rd == r.
  - Otherwise value(r) = rf[r] as it was before this edge.
  - With BYPASS=0, a same-cycle write is visible to a read of that register one cycle later.
- re=0: out1, out2, busy1, busy2 hold their values. Writes and scoreboard updates still occur.
- Scoreboard, one pending bit per implemented register, updated at posedge:
  - An accepted write clears pend[rd].
  - sb_set=1 sets pend[sb_rd].
  - If both target the same register in one cycle, set wins: the new producer is still outstanding.
  - sb_set to register 0 is ignored when ZERO_REG=1; sb_set with sb_rd >= NREGS is ignored.
- busy outputs: with re=1, busy1/busy2 <= the next-state pending bit of rs1/rs2, i.e. after this edge's set/clear, so they are consistent with bypass.
  - busy is 0 for out-of-range registers, and for register 0 when ZERO_REG=1.
- Simultaneous events:
  - rs1 == rs2 is legal; both ports return identical data.
  - we and sb_set on different registers in the same cycle are independent.
- Reset mid-stall: reset clears the outputs even when re=0.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset, then read all registers with re=1 -> out1=out2=0, busy1=busy2=0 every cycle.
- Write rd=5, inf=0xDEADBEEF; next cycle read rs1=5 -> out1=0xDEADBEEF one cycle after the read edge.
- BYPASS=1: rf[7]=0x11 already stored; same cycle we=1, rd=7, inf=0x22 and rs1=rs2=7 -> out1=out2=0x22. Repeat with BYPASS=0 -> 0x11, then 0x22 on the following read.
- ZERO_REG=1: we=1, rd=0, inf=0xFFFFFFFF, sb_set=1, sb_rd=0; then read rs1=0 -> out1=0, busy1=0.
- Scoreboard:
  - sb_set with sb_rd=3; read rs2=3 -> busy2=1.
  - Next cycle we=1, rd=3, sb_set=1, sb_rd=3 -> busy2 stays 1.
  - Next cycle we=1, rd=3, sb_set=0 -> busy2=0.
- re=0 for 3 cycles while writing rd=9 with inf=0x1234 (rs1=9) -> out1 holds its old value; re=1 -> out1=0x1234. Assert reset while re=0 -> out1=0 on the next edge.
